// File: rtl/reg_que_rr_reader.sv
// reg_que_rr_reader: dequeue side of the multi-queue register FIFO.
// A round-robin arbiter picks an eligible non-empty queue and drives a one-hot read strobe.
// The FIFO returns shared read data one cycle later. That word is captured into a 2-entry
// output buffer and presented on a valid/ready stream, tagged with its source queue id.
// Optional feature: define REG_QUE_RD_CNT_EN to build per-queue 32-bit dequeue counters on
// rd_cnt. Without it, rd_cnt is tied to zero.
module reg_que_rr_reader #(
    parameter int unsigned MQNUM   = 8,
    parameter int unsigned DWID    = 18,
    parameter int unsigned QWID    = 3,
    parameter int unsigned DBG_WID = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MQNUM-1:0]      nempty,
    input  logic [MQNUM-1:0]      naempty,
    input  logic [MQNUM-1:0]      qen,
    output logic [MQNUM-1:0]      ren,
    input  logic [DWID-1:0]       rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DWID-1:0]       m_data,
    output logic [QWID-1:0]       m_qid,
    output logic [32*MQNUM-1:0]   rd_cnt,
    output logic [DBG_WID-1:0]    dbg
);

    // Round-robin pointer, one-cycle read block, in-flight tag.
    logic [QWID-1:0]  last_q, last_d;
    logic [MQNUM-1:0] block_q, block_d;
    logic             inflight_q, inflight_d;
    logic [QWID-1:0]  inflight_qid_q, inflight_qid_d;

    // Output buffer. Entry 0 is the head.
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic [DWID-1:0]  buf_data_q [2];
    logic [DWID-1:0]  buf_data_d [2];
    logic [QWID-1:0]  buf_qid_q [2];
    logic [QWID-1:0]  buf_qid_d [2];

    logic [MQNUM-1:0]   eligible;
    logic [2*MQNUM-1:0] elig2;
    logic [MQNUM-1:0]   elig_rot;
    logic               found;
    int unsigned        off;
    int unsigned        win_i;
    logic [QWID-1:0]    win;
    logic [1:0]         occ;
    logic               pop;
    logic               push;
    logic               issue_ok;
    logic [1:0]         wr_idx;

    assign m_valid = (buf_cnt_q != 2'd0);
    assign m_data  = buf_data_q[0];
    assign m_qid   = buf_qid_q[0];

    // Arbitration: rotate eligibility so the search starts at last+1, then take the first set bit.
    always_comb begin
        // FIFO status lags one cycle, so a queue read last cycle needs naempty to be read again.
        eligible = nempty & qen & ~(block_q & ~naempty);
        pop      = m_valid & m_ready;
        occ      = buf_cnt_q + {1'b0, inflight_q};
        issue_ok = (occ < 2'd2) || ((occ == 2'd2) && pop);
        elig2    = {eligible, eligible} >> (32'(last_q) + 32'd1);
        elig_rot = elig2[MQNUM-1:0];
        found    = 1'b0;
        off      = 0;
        for (int unsigned j = 0; j < MQNUM; j++) begin
            if (!found && elig_rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        win_i = (32'(last_q) + 32'd1 + off) % MQNUM;
        win   = win_i[QWID-1:0];
        ren   = '0;
        if (rst && found && issue_ok) begin
            ren = MQNUM'(1) << win;
        end
        last_d         = (ren != '0) ? win : last_q;
        block_d        = ren;
        inflight_d     = (ren != '0);
        inflight_qid_d = (ren != '0) ? win : inflight_qid_q;
    end

    // Output buffer next state. Pop shifts entry 1 to the head; push writes behind the remaining entries.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_qid_d  = buf_qid_q;
        push       = inflight_q;
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_qid_d[0]  = buf_qid_q[1];
        end
        wr_idx = buf_cnt_q - {1'b0, pop};
        if (push) begin
            buf_data_d[wr_idx[0]] = rdata;
            buf_qid_d[wr_idx[0]]  = inflight_qid_q;
        end
        buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers with synchronous active-low reset. A read in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q         <= QWID'(MQNUM - 1);
            block_q        <= '0;
            inflight_q     <= 1'b0;
            inflight_qid_q <= '0;
            buf_cnt_q      <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_qid_q[i]  <= '0;
            end
        end else begin
            last_q         <= last_d;
            block_q        <= block_d;
            inflight_q     <= inflight_d;
            inflight_qid_q <= inflight_qid_d;
            buf_cnt_q      <= buf_cnt_d;
            buf_data_q     <= buf_data_d;
            buf_qid_q      <= buf_qid_d;
        end
    end

`ifdef REG_QUE_RD_CNT_EN
    logic [31:0] rd_cnt_q [MQNUM];
    logic [31:0] rd_cnt_d [MQNUM];

    // Per-queue dequeue counters. They wrap naturally at 32 bits.
    always_comb begin
        for (int unsigned q = 0; q < MQNUM; q++) begin
            rd_cnt_d[q] = rd_cnt_q[q] + 32'(ren[q]);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        for (int unsigned q = 0; q < MQNUM; q++) begin
            if (!rst) begin
                rd_cnt_q[q] <= '0;
            end else begin
                rd_cnt_q[q] <= rd_cnt_d[q];
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        rd_cnt = '0;
        for (int unsigned q = 0; q < MQNUM; q++) begin
            rd_cnt[32*q +: 32] = rd_cnt_q[q];
        end
    end
`else
    assign rd_cnt = '0;
`endif

    // Debug bus: {0.., inflight, buf_cnt, last}.
    always_comb begin
        dbg             = '0;
        dbg[QWID-1:0]   = last_q;
        dbg[QWID +: 2]  = buf_cnt_q;
        dbg[QWID + 2]   = inflight_q;
    end

endmodule

// File: tb/tb_reg_que_rr_reader.sv
// Testbench for reg_que_rr_reader.
// A behavioural multi-queue FIFO model feeds the DUT. Its status flags lag the queue
// contents by one cycle. Each read strobe pushes the expected {qid,data} word to a
// scoreboard. Each stream handshake pops a word from the scoreboard and compares it.
module tb_reg_que_rr_reader;
    localparam int MQNUM   = 8;
    localparam int DWID    = 18;
    localparam int QWID    = 3;
    localparam int DBG_WID = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [MQNUM-1:0]     nempty = '0;
    logic [MQNUM-1:0]     naempty = '0;
    logic [MQNUM-1:0]     qen = '1;
    logic [MQNUM-1:0]     ren;
    logic [DWID-1:0]      rdata = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic [DWID-1:0]      m_data;
    logic [QWID-1:0]      m_qid;
    logic [32*MQNUM-1:0]  rd_cnt;
    logic [DBG_WID-1:0]   dbg;

    reg_que_rr_reader #(
        .MQNUM(MQNUM), .DWID(DWID), .QWID(QWID), .DBG_WID(DBG_WID)
    ) dut (
        .clk(clk), .rst(rst), .nempty(nempty), .naempty(naempty), .qen(qen),
        .ren(ren), .rdata(rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_qid(m_qid), .rd_cnt(rd_cnt), .dbg(dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model
    logic [DWID-1:0]  fq [MQNUM][$];
    logic [MQNUM-1:0] na_mask = '0;
    logic [DWID-1:0]  rd_word;
    int               cyc = 0;
    int               serial = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int q = 0; q < MQNUM; q++) begin
            nempty[q]  <= (fq[q].size() != 0);
            naempty[q] <= (fq[q].size() > 1) && !na_mask[q];
            if (ren[q] && fq[q].size() != 0) begin
                rd_word = fq[q].pop_front();
                rdata <= rd_word;
            end
        end
    end

    // Scoreboard and monitor
    typedef struct packed {
        logic [QWID-1:0] qid;
        logic [DWID-1:0] data;
    } item_t;

    item_t           exp_q[$];
    item_t           e;
    int              ren_log[$];
    int              ren_cyc[$];
    int              pop_cnt = 0;
    int              pop_first = -1;
    int              pop_last = -1;
    logic            hold_v = 1'b0;
    logic [DWID-1:0] hold_d;
    logic [QWID-1:0] hold_id;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            hold_v = 1'b0;
        end else begin
            check_eq("ren_onehot0", 64'($onehot0(ren)), 64'd1);
            for (int q = 0; q < MQNUM; q++) begin
                if (ren[q]) begin
                    if (fq[q].size() == 0) begin
                        check_eq("ren_on_empty_q", 64'(q), 64'(MQNUM));
                    end else begin
                        exp_q.push_back('{qid: QWID'(q), data: fq[q][0]});
                    end
                    ren_log.push_back(q);
                    ren_cyc.push_back(cyc);
                end
            end
            if (hold_v) begin
                check_eq("hold_valid", 64'(m_valid), 64'd1);
                check_eq("hold_data", 64'(m_data), 64'(hold_d));
                check_eq("hold_qid", 64'(m_qid), 64'(hold_id));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_word_expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("m_qid", 64'(m_qid), 64'(e.qid));
                    check_eq("m_data", 64'(m_data), 64'(e.data));
                end
                pop_cnt++;
                if (pop_first < 0) pop_first = cyc;
                pop_last = cyc;
            end
            hold_v  = m_valid && !m_ready;
            hold_d  = m_data;
            hold_id = m_qid;
        end
    end

    function automatic int model_total();
        int t = 0;
        for (int q = 0; q < MQNUM; q++) t += fq[q].size();
        return t;
    endfunction

    task automatic load(input int q, input int n);
        for (int i = 0; i < n; i++) begin
            fq[q].push_back(DWID'(q * 4096 + serial));
            serial++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        ren_log.delete();
        ren_cyc.delete();
        pop_cnt   = 0;
        pop_first = -1;
        pop_last  = -1;
    endtask

    task automatic drain(input string tag, input int budget, input bit rand_ready);
        int k = 0;
        while (k < budget) begin
            @(negedge clk);
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            #2;
            if (exp_q.size() == 0 && model_total() == 0 && !m_valid) break;
            k++;
        end
        check_eq(tag, 64'(k < budget), 64'd1);
        m_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        step(2);
        exp_q.delete();
        rst = 1'b1;
    endtask

    initial begin
        int k;
        rst = 1'b0;
        m_ready = 1'b1;
        qen = '1;
        step(3);
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_data", 64'(m_data), 64'd0);
        check_eq("rst_m_qid", 64'(m_qid), 64'd0);
        check_eq("rst_ren", 64'(ren), 64'd0);
        check_eq("rst_dbg", 64'(dbg), 64'd7);
        check_eq("rst_rd_cnt", 64'(rd_cnt != '0), 64'd0);
        rst = 1'b1;

        // 1: all queues 3 deep, strict round-robin, no gaps
        clear_logs();
        for (int q = 0; q < MQNUM; q++) load(q, 3);
        drain("t1_drain", 200, 1'b0);
        check_eq("t1_ren_count", 64'(ren_log.size()), 64'd24);
        for (int i = 0; i < ren_log.size() && i < 24; i++)
            check_eq("t1_ren_order", 64'(ren_log[i]), 64'(i % MQNUM));
        check_eq("t1_pop_count", 64'(pop_cnt), 64'd24);
        check_eq("t1_no_gaps", 64'(pop_last - pop_first), 64'd23);

        // 2: single queue, naempty forced low then normal
        clear_logs();
        na_mask[5] = 1'b1;
        load(5, 2);
        drain("t2a_drain", 100, 1'b0);
        check_eq("t2a_ren_count", 64'(ren_log.size()), 64'd2);
        if (ren_cyc.size() == 2) check_eq("t2a_gap", 64'(ren_cyc[1] - ren_cyc[0]), 64'd2);
        na_mask = '0;
        step(2);
        clear_logs();
        load(5, 3);
        drain("t2b_drain", 100, 1'b0);
        check_eq("t2b_ren_count", 64'(ren_log.size()), 64'd3);
        if (ren_cyc.size() == 3) begin
            check_eq("t2b_gap0", 64'(ren_cyc[1] - ren_cyc[0]), 64'd1);
            check_eq("t2b_gap1", 64'(ren_cyc[2] - ren_cyc[1]), 64'd1);
        end

        // 3: backpressure from idle, then random ready during release
        clear_logs();
        m_ready = 1'b0;
        for (int q = 0; q < 4; q++) load(q, 2);
        step(10);
        check_eq("t3_ren_stall", 64'(ren_log.size()), 64'd2);
        drain("t3_drain", 400, 1'b1);
        check_eq("t3_ren_total", 64'(ren_log.size()), 64'd8);
        check_eq("t3_pop_total", 64'(pop_cnt), 64'd8);

        // 4: only q4..q7 enabled
        do_reset();
        clear_logs();
        qen = 8'hF0;
        for (int q = 0; q < MQNUM; q++) load(q, 2);
        step(20);
        check_eq("t4_ren_count", 64'(ren_log.size()), 64'd8);
        for (int i = 0; i < ren_log.size() && i < 8; i++)
            check_eq("t4_ren_order", 64'(ren_log[i]), 64'(4 + i % 4));
        qen = '1;
        drain("t4_drain", 300, 1'b0);

        // 5: reset in the cycle after ren[2]
        do_reset();
        clear_logs();
        load(2, 1);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            #2;
            if (ren_log.size() != 0) break;
            k++;
        end
        check_eq("t5_ren_seen", 64'(ren_log.size()), 64'd1);
        if (ren_log.size() != 0) check_eq("t5_ren_q", 64'(ren_log[0]), 64'd2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5_m_valid", 64'(m_valid), 64'd0);
        check_eq("t5_dbg", 64'(dbg), 64'd7);
        exp_q.delete();
        clear_logs();
        rst = 1'b1;
        load(3, 1);
        load(0, 1);
        drain("t5_drain", 100, 1'b0);
        check_eq("t5_ren_count", 64'(ren_log.size()), 64'd2);
        if (ren_log.size() != 0) check_eq("t5_first_grant", 64'(ren_log[0]), 64'd0);

        // 6: dequeue counters
        do_reset();
        load(1, 5);
        load(6, 3);
        drain("t6_drain", 100, 1'b0);
        for (int q = 0; q < MQNUM; q++) begin
`ifdef REG_QUE_RD_CNT_EN
            check_eq("t6_rd_cnt", 64'(rd_cnt[32*q +: 32]), (q == 1) ? 64'd5 : (q == 6) ? 64'd3 : 64'd0);
`else
            check_eq("t6_rd_cnt", 64'(rd_cnt[32*q +: 32]), 64'd0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
